// File: rtl/ddr3_phy_pkg.sv
// Shared definitions for the DDR3 x16 PHY command path: widths, command
// encodings and the packed command record carried into the PHY command FIFO.
package ddr3_phy_pkg;

  localparam int p_BANK_W = 3;
  localparam int p_ROW_W  = 14;
  localparam int p_COL_W  = 10;
  localparam int p_DQ_W   = 16;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  typedef struct packed {
    logic                  sel;
    logic [p_BANK_W-1:0]   bank;
    logic [p_ROW_W-1:0]    row;
    logic [p_COL_W-1:0]    col;
    logic [8*p_DQ_W-1:0]   wrdata;
    logic [7:0]            wrdm;
  } ddr3_cmd_t;

  typedef enum logic [0:0] {
    ST_WAIT_INIT = 1'b0,
    ST_RUN       = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ddr3_rr_grant.sv
// Two-way round-robin pick with a bounded run length: the most recent owner
// keeps the port until it has issued p_MAX_RUN commands while the other waits.
module ddr3_rr_grant #(
  parameter int p_MAX_RUN = 4
) (
  input  logic i_clk_div,
  input  logic i_rst,
  input  logic i_arb_en,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_hs,
  input  logic i_hs_id,
  output logic o_grant_vld,
  output logic o_grant_id,
  output logic o_last_grant
);
  import ddr3_phy_pkg::*;

  localparam logic [3:0] MAX_RUN_C = 4'(p_MAX_RUN);

  logic [3:0] run_cnt_r;
  logic       last_grant_r;
  logic       grant_vld_s;
  logic       grant_id_s;

  // Combinational pick among the valid requesters.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = last_grant_r;
    if (!i_arb_en) begin
      grant_vld_s = 1'b0;
      grant_id_s  = last_grant_r;
    end else if (i_valid0 && i_valid1) begin
      grant_vld_s = 1'b1;
      grant_id_s  = (run_cnt_r == MAX_RUN_C) ? ~last_grant_r : last_grant_r;
    end else if (i_valid0) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (i_valid1) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = last_grant_r;
    end
  end

  // Owner and run-length tracking; only moves on an accepted command.
  always_ff @(posedge i_clk_div or posedge i_rst) begin
    if (i_rst) begin
      run_cnt_r    <= 4'd0;
      last_grant_r <= 1'b0;
    end else if (i_hs) begin
      if (i_hs_id == last_grant_r) begin
        run_cnt_r <= (run_cnt_r == MAX_RUN_C) ? run_cnt_r : run_cnt_r + 4'd1;
      end else begin
        run_cnt_r    <= 4'd1;
        last_grant_r <= i_hs_id;
      end
    end
  end

  assign o_grant_vld  = grant_vld_s;
  assign o_grant_id   = grant_id_s;
  assign o_last_grant = last_grant_r;

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Shares the PHY command/write-data port between two requesters: holds off
// until PHY init is done, arbitrates round-robin, and issues a registered strobe.
module ddr3_cmd_arbiter #(
  parameter int p_BANK_W  = ddr3_phy_pkg::p_BANK_W,
  parameter int p_ROW_W   = ddr3_phy_pkg::p_ROW_W,
  parameter int p_COL_W   = ddr3_phy_pkg::p_COL_W,
  parameter int p_DQ_W    = ddr3_phy_pkg::p_DQ_W,
  parameter int p_MAX_RUN = 4
) (
  input  logic                  i_clk_div,
  input  logic                  i_rst,
  input  logic                  i_init_done,
  input  logic                  i_req0_valid,
  input  logic                  i_req1_valid,
  output logic                  o_req0_ready,
  output logic                  o_req1_ready,
  input  logic                  i_req0_sel,
  input  logic                  i_req1_sel,
  input  logic [p_BANK_W-1:0]   in_req0_bank,
  input  logic [p_BANK_W-1:0]   in_req1_bank,
  input  logic [p_ROW_W-1:0]    in_req0_row,
  input  logic [p_ROW_W-1:0]    in_req1_row,
  input  logic [p_COL_W-1:0]    in_req0_col,
  input  logic [p_COL_W-1:0]    in_req1_col,
  input  logic [8*p_DQ_W-1:0]   in_req0_wrdata,
  input  logic [8*p_DQ_W-1:0]   in_req1_wrdata,
  input  logic [7:0]            i8_req0_wrdm,
  input  logic [7:0]            i8_req1_wrdm,
  input  logic                  i_phy_cmd_full,
  output logic                  o_phy_cmd_en,
  output logic                  o_phy_cmd_sel,
  output logic [p_BANK_W-1:0]   on_phy_bank,
  output logic [p_ROW_W-1:0]    on_phy_row,
  output logic [p_COL_W-1:0]    on_phy_col,
  output logic [8*p_DQ_W-1:0]   on_phy_wrdata,
  output logic [7:0]            o8_phy_wrdm,
  output logic                  o_last_grant,
  output logic [15:0]           on_wr_cnt,
  output logic [15:0]           on_rd_cnt
);
  import ddr3_phy_pkg::*;

  arb_state_e state_r;
  arb_state_e state_nxt_s;

  logic arb_en_s;
  logic grant_vld_s;
  logic grant_id_s;
  logic ready0_s;
  logic ready1_s;
  logic hs_s;

  logic                cmd_en_r;
  logic                cmd_sel_r;
  logic [p_BANK_W-1:0] bank_r;
  logic [p_ROW_W-1:0]  row_r;
  logic [p_COL_W-1:0]  col_r;
  logic [8*p_DQ_W-1:0] wrdata_r;
  logic [7:0]          wrdm_r;
  logic [15:0]         wr_cnt_r;
  logic [15:0]         rd_cnt_r;

  // Init gating state register.
  always_ff @(posedge i_clk_div or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_WAIT_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state follows the sampled init flag; readies derive from the grant.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_WAIT_INIT: begin
        if (i_init_done) state_nxt_s = ST_RUN;
        else             state_nxt_s = ST_WAIT_INIT;
      end
      ST_RUN: begin
        if (!i_init_done) state_nxt_s = ST_WAIT_INIT;
        else              state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_WAIT_INIT;
    endcase
    arb_en_s = (state_r == ST_RUN) && !i_phy_cmd_full;
    ready0_s = grant_vld_s && (grant_id_s == 1'b0) && i_req0_valid;
    ready1_s = grant_vld_s && (grant_id_s == 1'b1) && i_req1_valid;
    hs_s     = ready0_s || ready1_s;
  end

  ddr3_rr_grant #(
    .p_MAX_RUN (p_MAX_RUN)
  ) u_rr_grant (
    .i_clk_div    (i_clk_div),
    .i_rst        (i_rst),
    .i_arb_en     (arb_en_s),
    .i_valid0     (i_req0_valid),
    .i_valid1     (i_req1_valid),
    .i_hs         (hs_s),
    .i_hs_id      (ready1_s),
    .o_grant_vld  (grant_vld_s),
    .o_grant_id   (grant_id_s),
    .o_last_grant (o_last_grant)
  );

  // Capture the accepted command; the strobe lives exactly one cycle.
  always_ff @(posedge i_clk_div or posedge i_rst) begin
    if (i_rst) begin
      cmd_en_r  <= 1'b0;
      cmd_sel_r <= 1'b0;
      bank_r    <= '0;
      row_r     <= '0;
      col_r     <= '0;
      wrdata_r  <= '0;
      wrdm_r    <= 8'h00;
    end else begin
      cmd_en_r <= hs_s;
      if (ready1_s) begin
        cmd_sel_r <= i_req1_sel;
        bank_r    <= in_req1_bank;
        row_r     <= in_req1_row;
        col_r     <= in_req1_col;
        wrdata_r  <= in_req1_wrdata;
        wrdm_r    <= i8_req1_wrdm;
      end else if (ready0_s) begin
        cmd_sel_r <= i_req0_sel;
        bank_r    <= in_req0_bank;
        row_r     <= in_req0_row;
        col_r     <= in_req0_col;
        wrdata_r  <= in_req0_wrdata;
        wrdm_r    <= i8_req0_wrdm;
      end
    end
  end

  // Debug issue counters, counted on the strobe cycle and wrapping.
  always_ff @(posedge i_clk_div or posedge i_rst) begin
    if (i_rst) begin
      wr_cnt_r <= 16'd0;
      rd_cnt_r <= 16'd0;
    end else if (cmd_en_r) begin
      if (cmd_sel_r == CMD_READ) rd_cnt_r <= rd_cnt_r + 16'd1;
      else                       wr_cnt_r <= wr_cnt_r + 16'd1;
    end
  end

  assign o_req0_ready  = ready0_s;
  assign o_req1_ready  = ready1_s;
  assign o_phy_cmd_en  = cmd_en_r;
  assign o_phy_cmd_sel = cmd_sel_r;
  assign on_phy_bank   = bank_r;
  assign on_phy_row    = row_r;
  assign on_phy_col    = col_r;
  assign on_phy_wrdata = wrdata_r;
  assign o8_phy_wrdm   = wrdm_r;
  assign on_wr_cnt     = wr_cnt_r;
  assign on_rd_cnt     = rd_cnt_r;

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed bench for ddr3_cmd_arbiter: a per-cycle reference model of the
// arbitration rules plus hand-computed expectations for each scenario.
module tb_ddr3_cmd_arbiter;

  localparam int BW   = 3;
  localparam int RW   = 14;
  localparam int CW   = 10;
  localparam int DW   = 16;
  localparam int MAXR = 4;
  localparam int NRD  = 65537;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic          s0, s1;
  logic [BW-1:0] b0, b1;
  logic [RW-1:0] r0, r1;
  logic [CW-1:0] c0, c1;
  logic [8*DW-1:0] d0, d1;
  logic [7:0]    m0, m1;
  logic          full = 1'b0;

  logic          rdy0, rdy1, en, sel, lastg;
  logic [BW-1:0] bank;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [8*DW-1:0] wdata;
  logic [7:0]    wdm;
  logic [15:0]   wr_cnt, rd_cnt;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  ddr3_cmd_arbiter #(
    .p_BANK_W(BW), .p_ROW_W(RW), .p_COL_W(CW), .p_DQ_W(DW), .p_MAX_RUN(MAXR)
  ) dut (
    .i_clk_div(clk), .i_rst(rst), .i_init_done(init),
    .i_req0_valid(v0), .i_req1_valid(v1),
    .o_req0_ready(rdy0), .o_req1_ready(rdy1),
    .i_req0_sel(s0), .i_req1_sel(s1),
    .in_req0_bank(b0), .in_req1_bank(b1),
    .in_req0_row(r0), .in_req1_row(r1),
    .in_req0_col(c0), .in_req1_col(c1),
    .in_req0_wrdata(d0), .in_req1_wrdata(d1),
    .i8_req0_wrdm(m0), .i8_req1_wrdm(m1),
    .i_phy_cmd_full(full),
    .o_phy_cmd_en(en), .o_phy_cmd_sel(sel),
    .on_phy_bank(bank), .on_phy_row(row), .on_phy_col(col),
    .on_phy_wrdata(wdata), .o8_phy_wrdm(wdm),
    .o_last_grant(lastg), .on_wr_cnt(wr_cnt), .on_rd_cnt(rd_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model state
  bit            m_run = 1'b0;
  bit            m_owner = 1'b0;
  int            m_len = 0;
  bit            m_en = 1'b0;
  bit            m_sel = 1'b0;
  logic [BW-1:0] m_bank = '0;
  logic [RW-1:0] m_row = '0;
  logic [CW-1:0] m_col = '0;
  logic [8*DW-1:0] m_data = '0;
  logic [7:0]    m_dm = 8'h00;
  int            m_wr = 0;
  int            m_rd = 0;

  // Compare process: check mid-cycle, then advance the model to the next edge.
  initial begin
    bit gv, gid, e0, e1;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_run = 0; m_owner = 0; m_len = 0; m_en = 0; m_sel = 0;
        m_bank = '0; m_row = '0; m_col = '0; m_data = '0; m_dm = 8'h00;
        m_wr = 0; m_rd = 0;
      end
      gv = 0; gid = 0;
      if (m_run && !full) begin
        if (v0 && v1) begin
          gv = 1;
          gid = (m_len >= MAXR) ? !m_owner : m_owner;
        end else if (v0) begin
          gv = 1; gid = 0;
        end else if (v1) begin
          gv = 1; gid = 1;
        end
      end
      e0 = gv && !gid && v0;
      e1 = gv && gid && v1;
      chk("m_ready0", rdy0, e0);
      chk("m_ready1", rdy1, e1);
      chk("m_cmd_en", en, m_en);
      chk("m_sel", sel, m_sel);
      chk("m_bank", bank, m_bank);
      chk("m_row", row, m_row);
      chk("m_col", col, m_col);
      chk("m_wrdata", wdata, m_data);
      chk("m_wrdm", wdm, m_dm);
      chk("m_last_grant", lastg, m_owner);
      chk("m_wr_cnt", wr_cnt, m_wr[15:0]);
      chk("m_rd_cnt", rd_cnt, m_rd[15:0]);
      if (en) strobes++;
      if (!rst) begin
        if (m_en) begin
          if (m_sel) m_rd = (m_rd + 1) % 65536;
          else       m_wr = (m_wr + 1) % 65536;
        end
        m_en = e0 || e1;
        if (e0) begin
          m_sel = s0; m_bank = b0; m_row = r0; m_col = c0; m_data = d0; m_dm = m0;
        end
        if (e1) begin
          m_sel = s1; m_bank = b1; m_row = r1; m_col = c1; m_data = d1; m_dm = m1;
        end
        if (e0 || e1) begin
          if (gid == m_owner) m_len = (m_len < MAXR) ? m_len + 1 : MAXR;
          else begin
            m_owner = gid;
            m_len = 1;
          end
        end
        m_run = init;
      end
    end
  end

  // Directed stimulus with literal expectations.
  initial begin
    bit pat_a [12] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    bit pat_b [8]  = '{1, 1, 1, 0, 0, 0, 0, 1};
    int n;
    int cyc;
    s0 = 1'b0; b0 = 3'd4; r0 = 14'd13; c0 = 10'd8;
    d0 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff; m0 = 8'hFF;
    s1 = 1'b1; b1 = 3'd2; r1 = 14'h1234; c1 = 10'h155;
    d1 = 128'hdead_beef_0000_1111_2222_3333_4444_5555; m1 = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_cmd_en", en, 1'b0);
    chk("reset_wr_cnt", wr_cnt, 16'd0);
    chk("reset_rd_cnt", rd_cnt, 16'd0);
    chk("reset_last_grant", lastg, 1'b0);
    chk("reset_ready0", rdy0, 1'b0);

    rst = 1'b0;
    v0 = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("init_hold_strobes", strobes, 0);
    chk("init_hold_ready0", rdy0, 1'b0);

    init = 1'b1;
    #1;
    chk("ready_before_run", rdy0, 1'b0);
    @(posedge clk);
    #2;
    chk("ready_in_run", rdy0, 1'b1);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    #1;
    chk("wr_cmd_en", en, 1'b1);
    chk("wr_sel", sel, 1'b0);
    chk("wr_bank", bank, 3'd4);
    chk("wr_row", row, 14'd13);
    chk("wr_col", col, 10'd8);
    chk("wr_data", wdata, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff);
    chk("wr_dm", wdm, 8'hFF);
    @(posedge clk);
    #1;
    chk("wr_single_strobe", en, 1'b0);
    chk("wr_cnt_one", wr_cnt, 16'd1);

    v0 = 1'b1;
    v1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("rr_pattern", {rdy1, rdy0}, {pat_a[i], !pat_a[i]});
      @(posedge clk);
      #1;
    end
    chk("rr_last_grant", lastg, 1'b1);

    full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("full_readies", {rdy1, rdy0}, 2'b00);
      chk("full_strobe", en, (i == 0) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
    end
    full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("resume_pattern", {rdy1, rdy0}, {pat_b[i], !pat_b[i]});
      @(posedge clk);
      #1;
    end

    v0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_cmd_en", en, 1'b0);
    chk("midrst_wr_cnt", wr_cnt, 16'd0);
    chk("midrst_rd_cnt", rd_cnt, 16'd0);
    chk("midrst_last_grant", lastg, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_wait_init", rdy1, 1'b0);

    n = 0;
    cyc = 0;
    while (n < NRD && cyc < 70000) begin
      if (rdy1) n++;
      @(posedge clk);
      #1;
      if (n >= NRD) v1 = 1'b0;
      #1;
      cyc++;
    end
    v1 = 1'b0;
    chk("wrap_handshakes", n, NRD);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_rd_cnt", rd_cnt, 16'd1);
    chk("wrap_wr_cnt", wr_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
